// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Stage-boundary field layouts, control masks and skid FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    // IF/ID: PC and fetched instruction, no control fields.
    localparam int          IF_ID_W           = 64;
    localparam int          IF_ID_PC_LSB      = 0;
    localparam int          IF_ID_INSTR_LSB   = 32;
    localparam logic [63:0] IF_ID_CTRL_MASK   = '0;

    // ID/EX: bits 75..92 are reserved.
    localparam int          ID_EX_W           = 93;
    localparam int          ID_EX_A_LSB       = 0;
    localparam int          ID_EX_A_MSB       = 31;
    localparam int          ID_EX_B_LSB       = 32;
    localparam int          ID_EX_B_MSB       = 63;
    localparam int          ID_EX_WE_BIT      = 64;
    localparam int          ID_EX_ALU_LSB     = 65;
    localparam int          ID_EX_ALU_MSB     = 68;
    localparam int          ID_EX_DEST_LSB    = 69;
    localparam int          ID_EX_DEST_MSB    = 73;
    localparam int          ID_EX_CIN_BIT     = 74;
    localparam int          ID_EX_RSVD_LSB    = 75;
    localparam logic [92:0] ID_EX_CTRL_MASK   = {18'b0, 1'b1, 5'b0, 4'hF, 1'b1, 64'b0};

    // EX/MEM: result, store data, dest, then WE / MEMWR / MEMRD controls.
    localparam int          EX_MEM_W          = 72;
    localparam int          EX_MEM_RES_LSB    = 0;
    localparam int          EX_MEM_SDATA_LSB  = 32;
    localparam int          EX_MEM_DEST_LSB   = 64;
    localparam int          EX_MEM_WE_BIT     = 69;
    localparam int          EX_MEM_MEMWR_BIT  = 70;
    localparam int          EX_MEM_MEMRD_BIT  = 71;
    localparam logic [71:0] EX_MEM_CTRL_MASK  = {3'b111, 69'b0};

    // MEM/WB: writeback value, dest, WE.
    localparam int          MEM_WB_W          = 38;
    localparam int          MEM_WB_RES_LSB    = 0;
    localparam int          MEM_WB_DEST_LSB   = 32;
    localparam int          MEM_WB_WE_BIT     = 37;
    localparam logic [37:0] MEM_WB_CTRL_MASK  = {1'b1, 37'b0};

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : 2-entry elastic stage (main + skid register) with registered ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 93,
    parameter logic [WIDTH-1:0] CTRL_MASK = '0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skid_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_acc_in;
    logic             w_acc_out;

    assign w_acc_in  = in_valid & r_in_ready;
    assign w_acc_out = r_out_valid & out_ready & ~stall;

    // in_ready is updated alongside the state so it is low exactly in ST_TWO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main      <= r_main & ~CTRL_MASK;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc_in) begin
                        r_state     <= ST_ONE;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc_in && w_acc_out) begin
                        r_main <= in_data;
                    end else if (w_acc_in) begin
                        r_state    <= ST_TWO;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                    end else if (w_acc_out) begin
                        r_state     <= ST_EMPTY;
                        r_main      <= r_main & ~CTRL_MASK;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_acc_out) begin
                        r_state    <= ST_ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;

endmodule : pipe_stage_skid
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Generic pipeline stage register with valid, stall, flush, elastic.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 93,
    parameter logic [WIDTH-1:0] CTRL_MASK = '0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               ELASTIC   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    generate
        if (ELASTIC) begin : g_elastic
            pipe_stage_skid #(
                .WIDTH     (WIDTH),
                .CTRL_MASK (CTRL_MASK),
                .RESET_VAL (RESET_VAL)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (in_data),
                .stall     (stall),
                .flush     (flush),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (out_data),
                .occupancy (occupancy)
            );
        end else begin : g_single
            logic [WIDTH-1:0] r_data;
            logic             r_valid;
            logic             w_unused_out_ready;

            // Downstream backpressure has no meaning for a plain register.
            assign w_unused_out_ready = out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data  <= RESET_VAL;
                    r_valid <= 1'b0;
                end else if (flush) begin
                    r_data  <= r_data & ~CTRL_MASK;
                    r_valid <= 1'b0;
                end else if (!stall) begin
                    r_data  <= in_valid ? in_data : (in_data & ~CTRL_MASK);
                    r_valid <= in_valid;
                end
            end

            assign in_ready  = ~stall;
            assign out_valid = r_valid;
            assign out_data  = r_data;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for single-register and elastic stage variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W = ID_EX_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s_in_valid, s_in_ready, s_stall, s_flush, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [1:0]   s_occ;
    logic         e_in_valid, e_in_ready, e_stall, e_flush, e_out_valid, e_out_ready;
    logic [W-1:0] e_in_data, e_out_data;
    logic [1:0]   e_occ;

    int           n_checks = 0;
    int           n_errors = 0;
    int           n_pops   = 0;
    logic [W-1:0] sb_q[$];

    pipe_stage_reg #(
        .WIDTH(W), .CTRL_MASK(ID_EX_CTRL_MASK), .RESET_VAL('0), .ELASTIC(1'b0)
    ) u_single (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .stall(s_stall), .flush(s_flush),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    pipe_stage_reg #(
        .WIDTH(W), .CTRL_MASK(ID_EX_CTRL_MASK), .RESET_VAL('0), .ELASTIC(1'b1)
    ) u_elastic (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .stall(e_stall), .flush(e_flush),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
        .occupancy(e_occ)
    );

    function automatic logic [W-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // One clock: score elastic handshakes that complete at this edge, then advance.
    task automatic tick();
        logic [W-1:0] exp;
        if (!rst && !e_flush && e_out_valid && e_out_ready && !e_stall) begin
            n_checks++;
            n_pops++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_underflow: got %h, expected no output", e_out_data);
            end else begin
                exp = sb_q.pop_front();
                if (e_out_data !== exp) begin
                    n_errors++;
                    $display("FAIL sb_data: got %h, expected %h", e_out_data, exp);
                end
            end
        end
        if (!rst && !e_flush && e_in_valid && e_in_ready) sb_q.push_back(e_in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_in_valid = 1'b1; s_in_data = 93'h1_FFFF;
        e_in_valid = 1'b1; e_in_data = 93'h1_FFFF;
        tick(); tick();
        n_checks++; if (s_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_s_valid: got %b, expected 0", s_out_valid); end
        n_checks++; if (s_out_data !== '0) begin n_errors++; $display("FAIL rst_s_data: got %h, expected 0", s_out_data); end
        n_checks++; if (s_occ !== 2'd0) begin n_errors++; $display("FAIL rst_s_occ: got %0d, expected 0", s_occ); end
        n_checks++; if (s_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_s_ready: got %b, expected 1", s_in_ready); end
        n_checks++; if (e_out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_e_valid: got %b, expected 0", e_out_valid); end
        n_checks++; if (e_out_data !== '0) begin n_errors++; $display("FAIL rst_e_data: got %h, expected 0", e_out_data); end
        n_checks++; if (e_occ !== 2'd0) begin n_errors++; $display("FAIL rst_e_occ: got %0d, expected 0", e_occ); end
        n_checks++; if (e_in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_e_ready: got %b, expected 1", e_in_ready); end
        rst = 1'b0;
        s_in_data = 93'hCAFE; e_in_data = 93'hCAFE;
        tick();
        n_checks++; if (s_out_data !== 93'hCAFE || s_out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_first_s: got %h/%b, expected cafe/1", s_out_data, s_out_valid); end
        n_checks++; if (e_occ !== 2'd1 || e_out_valid !== 1'b1) begin n_errors++; $display("FAIL rst_first_e: got occ %0d valid %b, expected 1/1", e_occ, e_out_valid); end
        s_in_valid = 1'b0; e_in_valid = 1'b0; e_out_ready = 1'b1;
        tick();
        e_out_ready = 1'b0;
        n_checks++; if (e_occ !== 2'd0) begin n_errors++; $display("FAIL rst_drain_e: got occ %0d, expected 0", e_occ); end
    endtask

    task automatic test_stall();
        s_in_valid = 1'b1; s_in_data = 93'hA5A5;
        tick();
        n_checks++; if (s_out_data !== 93'hA5A5) begin n_errors++; $display("FAIL stall_load: got %h, expected a5a5", s_out_data); end
        s_stall = 1'b1; s_in_data = 93'h1234;
        #1;
        n_checks++; if (s_in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready: got %b, expected 0", s_in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (s_out_data !== 93'hA5A5 || s_out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_hold%0d: got %h/%b, expected a5a5/1", i, s_out_data, s_out_valid); end
        end
        s_stall = 1'b0;
        tick();
        n_checks++; if (s_out_data !== 93'h1234) begin n_errors++; $display("FAIL stall_release: got %h, expected 1234", s_out_data); end
    endtask

    task automatic test_flush_mask();
        logic [W-1:0] fl, bub;
        fl = '0;
        fl[ID_EX_A_MSB:ID_EX_A_LSB]       = 32'hDEAD_BEEF;
        fl[ID_EX_B_MSB:ID_EX_B_LSB]       = 32'h0123_4567;
        fl[ID_EX_WE_BIT]                  = 1'b1;
        fl[ID_EX_ALU_MSB:ID_EX_ALU_LSB]   = 4'hF;
        fl[ID_EX_DEST_MSB:ID_EX_DEST_LSB] = 5'h1A;
        fl[ID_EX_CIN_BIT]                 = 1'b1;
        bub = fl;
        bub[ID_EX_WE_BIT] = 1'b0;
        bub[ID_EX_ALU_MSB:ID_EX_ALU_LSB] = 4'h0;
        bub[ID_EX_CIN_BIT] = 1'b0;
        s_in_valid = 1'b1; s_in_data = fl;
        tick();
        n_checks++; if (s_out_data !== fl) begin n_errors++; $display("FAIL flush_load: got %h, expected %h", s_out_data, fl); end
        s_flush = 1'b1; s_stall = 1'b1; s_in_data = 93'h55;
        tick();
        n_checks++; if (s_out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b, expected 0", s_out_valid); end
        n_checks++; if (s_out_data !== bub) begin n_errors++; $display("FAIL flush_bubble: got %h, expected %h", s_out_data, bub); end
        s_flush = 1'b0; s_stall = 1'b0; s_in_valid = 1'b0; s_in_data = fl;
        tick();
        n_checks++; if (s_out_data !== bub || s_occ !== 2'd0) begin n_errors++; $display("FAIL invalid_mask: got %h occ %0d, expected %h occ 0", s_out_data, s_occ, bub); end
    endtask

    task automatic test_skid_fill();
        e_out_ready = 1'b0; e_in_valid = 1'b1; e_in_data = 93'd1;
        tick();
        n_checks++; if (e_occ !== 2'd1 || e_in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_one: got occ %0d rdy %b, expected 1/1", e_occ, e_in_ready); end
        e_in_data = 93'd2;
        tick();
        n_checks++; if (e_occ !== 2'd2 || e_in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_two: got occ %0d rdy %b, expected 2/0", e_occ, e_in_ready); end
        e_in_data = 93'd3;
        tick();
        n_checks++; if (e_occ !== 2'd2 || e_out_data !== 93'd1) begin n_errors++; $display("FAIL fill_hold: got occ %0d data %h, expected 2/1", e_occ, e_out_data); end
        e_out_ready = 1'b1;
        tick();
        n_checks++; if (e_occ !== 2'd1 || e_in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_drain1: got occ %0d rdy %b, expected 1/1", e_occ, e_in_ready); end
        tick();
        e_in_valid = 1'b0;
        tick();
        n_checks++; if (e_occ !== 2'd0 || e_out_valid !== 1'b0) begin n_errors++; $display("FAIL fill_empty: got occ %0d valid %b, expected 0/0", e_occ, e_out_valid); end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL fill_sb_left: got %0d entries, expected 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        int blocked, start_pops, accepted, cycles;
        e_out_ready = 1'b1; e_in_valid = 1'b1; blocked = 0; start_pops = n_pops;
        for (int i = 0; i < 100; i++) begin
            e_in_data = rand_word();
            if (!e_in_ready) blocked++;
            tick();
        end
        e_in_valid = 1'b0;
        tick();
        n_checks++; if (n_pops - start_pops != 100) begin n_errors++; $display("FAIL b2b_rate: got %0d beats out, expected 100", n_pops - start_pops); end
        n_checks++; if (blocked != 0) begin n_errors++; $display("FAIL b2b_ready: got %0d blocked cycles, expected 0", blocked); end
        // Second pass: random backpressure and stall, upstream holds until accepted.
        start_pops = n_pops; accepted = 0; cycles = 0;
        e_in_valid = 1'b1; e_in_data = rand_word();
        while (accepted < 100 && cycles < 2000) begin
            e_out_ready = ($urandom_range(0, 3) != 0);
            e_stall     = ($urandom_range(0, 7) == 0);
            if (e_in_ready) begin
                accepted++;
                tick();
                e_in_data = rand_word();
            end else begin
                tick();
            end
            cycles++;
        end
        e_in_valid = 1'b0; e_stall = 1'b0; e_out_ready = 1'b1;
        for (int i = 0; i < 10 && e_occ != 2'd0; i++) tick();
        n_checks++; if (accepted != 100 || e_occ !== 2'd0) begin n_errors++; $display("FAIL rand_timeout: got %0d accepted occ %0d, expected 100/0", accepted, e_occ); end
        n_checks++; if (n_pops - start_pops != 100) begin n_errors++; $display("FAIL rand_count: got %0d beats out, expected 100", n_pops - start_pops); end
        n_checks++; if (sb_q.size() != 0) begin n_errors++; $display("FAIL rand_sb_left: got %0d entries, expected 0", sb_q.size()); end
    endtask

    task automatic test_flush_collision();
        logic [W-1:0] fl, bub;
        fl = '0;
        fl[ID_EX_A_MSB:ID_EX_A_LSB] = 32'h0000_0011;
        fl[ID_EX_WE_BIT] = 1'b1;
        fl[ID_EX_ALU_MSB:ID_EX_ALU_LSB] = 4'h9;
        bub = fl;
        bub[ID_EX_WE_BIT] = 1'b0;
        bub[ID_EX_ALU_MSB:ID_EX_ALU_LSB] = 4'h0;
        e_out_ready = 1'b0; e_in_valid = 1'b1; e_in_data = fl;
        tick();
        e_in_data = 93'h22;
        tick();
        n_checks++; if (e_occ !== 2'd2) begin n_errors++; $display("FAIL coll_setup: got occ %0d, expected 2", e_occ); end
        e_flush = 1'b1; e_in_data = 93'hBAD;
        tick();
        sb_q.delete();
        e_flush = 1'b0;
        n_checks++; if (e_occ !== 2'd0 || e_out_valid !== 1'b0 || e_in_ready !== 1'b1) begin n_errors++; $display("FAIL coll_state: got occ %0d valid %b rdy %b, expected 0/0/1", e_occ, e_out_valid, e_in_ready); end
        n_checks++; if (e_out_data !== bub) begin n_errors++; $display("FAIL coll_bubble: got %h, expected %h", e_out_data, bub); end
        e_in_data = 93'h77;
        tick();
        e_in_valid = 1'b0; e_out_ready = 1'b1;
        tick();
        n_checks++; if (e_occ !== 2'd0 || sb_q.size() != 0) begin n_errors++; $display("FAIL coll_after: got occ %0d sb %0d, expected 0/0", e_occ, sb_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_stall = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        e_in_valid = 1'b0; e_in_data = '0; e_stall = 1'b0; e_flush = 1'b0; e_out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_stall();
        test_flush_mask();
        test_skid_fill();
        test_back_to_back();
        test_flush_collision();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that generalises the fixed 93-bit ID/EX register to any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
Adds a valid bit, stall (hold), flush (bubble insertion with control-field masking) and an optional elastic mode. Elastic mode is a 2-entry skid buffer with valid/ready handshake.
Sits between pipeline stages; the hazard unit drives stall/flush.

Parameters:
WIDTH, 93, payload width in bits
CTRL_MASK, {WIDTH{1'b0}}, bits set = control fields (WE, ALU ctl, Cin...) forced to 0 in any bubble
RESET_VAL, {WIDTH{1'b0}}, out_data value after reset
ELASTIC, 0, 0 = single register with stall/flush; 1 = 2-entry skid buffer with valid/ready

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (ELASTIC=0: ~stall; ELASTIC=1: registered, skid slot empty)
in_data  in  WIDTH  upstream payload
stall  in  1  hold current contents
flush  in  1  discard contents, insert bubble
out_valid  out  1  out_data holds a real instruction
out_ready  in  1  downstream accept (ELASTIC=0: ignored)
out_data  out  WIDTH  registered payload
occupancy  out  2  entries held (0..1 when ELASTIC=0, 0..2 when ELASTIC=1)

Behaviour:
- Priority every cycle: rst > flush > stall > normal update.
- Reset: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (ELASTIC=1) / ~stall (ELASTIC=0), skid slot empty.
- Bubble value: previous out_data & ~CTRL_MASK, so non-control fields stay stable and control fields are 0.
- ELASTIC=0:
  - Normal: out_data <= in_valid ? in_data : (in_data & ~CTRL_MASK); out_valid <= in_valid. Latency 1 cycle.
  - stall: all outputs hold. in_ready=0 combinationally.
  - flush: out_valid<=0; out_data <= bubble value. Flush with stall: flush wins.
- ELASTIC=1:
  - State = occupancy: EMPTY(0), ONE(1), TWO(2).
  - acc_in = in_valid & in_ready. acc_out = out_valid & out_ready & ~stall.
  - EMPTY: acc_in -> ONE; main reg <= in_data.
  - ONE: acc_in & acc_out -> ONE, main <= in_data. acc_in only -> TWO, skid <= in_data. acc_out only -> EMPTY, main <= bubble value.
  - TWO: acc_out -> ONE, main <= skid. in_ready=0, so no acc_in is possible.
  - in_ready is a register: 1 iff the next state is not TWO. There is no combinational path from out_ready to in_ready.
  - out_valid = (occupancy != 0), registered. Throughput is 1/cycle with zero bubbles while out_ready stays high.
  - flush: occupancy->0, skid discarded, main <= bubble value, in_ready<=1. A same-cycle in_valid payload is dropped.
  - stall: blocks acc_out only; upstream may still fill the skid slot.
- Payload ordering is strictly FIFO. Data is never duplicated or lost except by flush.
- Reset or flush mid-transfer discards all held entries. No partial state survives.

Decomposition:
- Package pipe_pkg holds:
  - ID/EX field offsets: A[31:0], B[63:32], WE 64, ALU[68:65], DEST[73:69], CIN 74, ID_EX_W=93, plus reserved bits.
  - ID_EX_CTRL_MASK with bits 64..68 and 74 set.
  - Equivalent constants for the other stage boundaries.
- Sub-module pipe_stage_skid is the 2-entry elastic datapath and occupancy FSM. It is instantiated under generate when ELASTIC=1. The ELASTIC=0 path is inline.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=93'h1_FFFF -> out_valid=0, out_data=0, occupancy=0. First post-reset valid input appears on out_data exactly 1 cycle later.
- Stall (ELASTIC=0): load 0xA5A5, assert stall 3 cycles while in_data=0x1234 -> out_data holds 0xA5A5, in_ready=0. Deassert -> 0x1234 appears next cycle.
- Flush masks control (CTRL_MASK=ID_EX_CTRL_MASK): out_data has WE=1, ALU=4'hF, CIN=1, A=32'hDEAD_BEEF; pulse flush -> out_valid=0, WE/ALU/CIN=0, A unchanged.
- Skid fill (ELASTIC=1): out_ready=0, send 3 beats 1,2,3 -> occupancy 1 then 2, in_ready=0 after beat 2, beat 3 held upstream. Raise out_ready -> outputs 1,2,3 in order, no loss.
- Full throughput (ELASTIC=1): out_ready=1, 100 back-to-back beats (random out_ready deassertions in a second pass) -> output sequence matches input scoreboard, 1 beat/cycle when unstalled.
- Flush+input collision (ELASTIC=1): occupancy=2, flush and in_valid=1 in same cycle -> next cycle occupancy=0, out_valid=0, in_ready=1, colliding beat absent from output.
